// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary-network post-ALU stages.
// Holds the FSM states, one-hot kernel codes, K2 lookup and default widths.
package bnn_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH} state_t;

   localparam logic [4:0] KS_1X1 = 5'b00001;
   localparam logic [4:0] KS_2X2 = 5'b00010;
   localparam logic [4:0] KS_3X3 = 5'b00100;
   localparam logic [4:0] KS_4X4 = 5'b01000;
   localparam logic [4:0] KS_5X5 = 5'b10000;

   localparam int DEF_ACC_W  = 16;
   localparam int DEF_NCH_W  = 8;
   localparam int DEF_PACK_W = 8;

   // Lowest set bit wins, so a malformed multi-hot code still maps to one size.
   function automatic logic [4:0] k2_of(input logic [4:0] ks);
      if (ks[0])      return 5'd1;
      else if (ks[1]) return 5'd4;
      else if (ks[2]) return 5'd9;
      else if (ks[3]) return 5'd16;
      else if (ks[4]) return 5'd25;
      else            return 5'd0;
   endfunction

endpackage

// File: rtl/act_packer.sv
// Packs activation bits LSB-first into PACK_W-bit words; partial words on flush.
// Word appears 1 cycle after its last bit; out_word/out_valid hold while !out_ready.
// Caller must only push bits when the output slot is free (!out_valid || out_ready).
module act_packer #(
   parameter int PACK_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_vld,
   input  logic              bit_dat,
   input  logic              flush_vld,
   input  logic              out_ready,
   output logic [PACK_W-1:0] out_word,
   output logic              out_valid,
   output logic              bit_cnt_nz
);

   localparam int CW = $clog2(PACK_W);

   logic [CW-1:0]     bit_cnt;
   logic [PACK_W-1:0] pack;
   logic [PACK_W-1:0] pack_nxt;
   logic              slot_free;
   logic              word_full;

   always_comb begin
      pack_nxt          = pack;
      pack_nxt[bit_cnt] = bit_dat;
   end

   assign slot_free  = !out_valid || out_ready;
   assign word_full  = (bit_cnt == CW'(PACK_W - 1));
   assign bit_cnt_nz = (bit_cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         pack      <= '0;
         out_word  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         // A fresh word overrides the handshake clear above, keeping out_valid high.
         if (bit_vld && word_full) begin
            out_word  <= pack_nxt;
            out_valid <= 1'b1;
            pack      <= '0;
            bit_cnt   <= '0;
         end else if (bit_vld) begin
            pack    <= pack_nxt;
            bit_cnt <= bit_cnt + CW'(1);
         end else if (flush_vld && slot_free) begin
            out_word  <= pack;
            out_valid <= 1'b1;
            pack      <= '0;
            bit_cnt   <= '0;
         end
      end
   end

endmodule

// File: rtl/popcount_threshold_packer.sv
// Accumulates popcounts per pixel, thresholds the bipolar dot product, packs bits.
// Result bit lands in the packer on the last beat's edge; full word valid 1 cycle later.
// mac_ready drops while a word is stalled or a flush is draining; POPACC_SAT_EN saturates the accumulator.
module popcount_threshold_packer
   import bnn_pkg::*;
#(
   parameter int ACC_W  = DEF_ACC_W,
   parameter int NCH_W  = DEF_NCH_W,
   parameter int PACK_W = DEF_PACK_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4:0]              mac_in,
   input  logic                    mac_valid,
   output logic                    mac_ready,
   input  logic [4:0]              kernel_size,
   input  logic                    operation,
   input  logic [NCH_W-1:0]        num_ch,
   input  logic signed [ACC_W+1:0] threshold,
   input  logic                    flush,
   output logic [PACK_W-1:0]       out_word,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    sat_flag
);

   localparam int THR_W = ACC_W + 2;

   typedef struct packed {
      logic [4:0]       k2;
      logic [NCH_W-1:0] nch;
      logic [THR_W-1:0] thr;
   } cfg_t;

   state_t           state;
   cfg_t             cfg_q, cfg_live, cfg_use;
   logic [ACC_W-1:0] acc, acc_base, sum;
   logic [NCH_W-1:0] ch_cnt;
   logic [THR_W-1:0] dot;
   logic             flush_pend, beat_acc, pool_beat, last_beat;
   logic             act_bit, act_vld, bit_cnt_nz;

   assign mac_ready = (state != S_FLUSH) && (!out_valid || out_ready);
   assign beat_acc  = mac_valid && mac_ready;
   assign busy      = (state != S_IDLE) || bit_cnt_nz || out_valid;

   // Live config applies to the first beat of a pixel; the held copy to the rest.
   assign cfg_live.k2  = k2_of(kernel_size);
   assign cfg_live.nch = (num_ch == '0) ? NCH_W'(1) : num_ch;
   assign cfg_live.thr = threshold;
   assign cfg_use      = (state == S_ACC) ? cfg_q : cfg_live;

   assign pool_beat = (state == S_IDLE) && operation;
   assign last_beat = pool_beat ||
                      ((state == S_IDLE) ? (cfg_live.nch == NCH_W'(1))
                                         : (ch_cnt == cfg_q.nch - NCH_W'(1)));
   assign acc_base  = (state == S_ACC) ? acc : '0;

`ifdef POPACC_SAT_EN
   logic [ACC_W:0] sum_ext;
   assign sum_ext = {1'b0, acc_base} + (ACC_W+1)'(mac_in);
   assign sum     = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sat_flag <= 1'b0;
      else if (beat_acc && sum_ext[ACC_W])
         sat_flag <= 1'b1;
   end
`else
   assign sum      = acc_base + ACC_W'(mac_in);
   assign sat_flag = 1'b0;
`endif

   // Modular arithmetic at THR_W bits matches the truncated signed result exactly.
   assign dot     = (THR_W'(sum) << 1) - THR_W'(cfg_use.nch) * THR_W'(cfg_use.k2);
   assign act_bit = pool_beat ? mac_in[0] : ($signed(dot) >= $signed(cfg_use.thr));
   assign act_vld = beat_acc && last_beat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         acc        <= '0;
         ch_cnt     <= '0;
         cfg_q      <= '0;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (beat_acc) begin
                  if (!last_beat) begin
                     acc    <= sum;
                     ch_cnt <= NCH_W'(1);
                     cfg_q  <= cfg_live;
                     state  <= S_ACC;
                  end
                  if (flush)
                     flush_pend <= 1'b1;
               end else if (flush || flush_pend) begin
                  flush_pend <= 1'b0;
                  if (bit_cnt_nz)
                     state <= S_FLUSH;
               end
            end
            S_ACC: begin
               if (flush)
                  flush_pend <= 1'b1;
               if (beat_acc) begin
                  if (last_beat) begin
                     acc    <= '0;
                     ch_cnt <= '0;
                     state  <= S_IDLE;
                  end else begin
                     acc    <= sum;
                     ch_cnt <= ch_cnt + NCH_W'(1);
                  end
               end
            end
            S_FLUSH: begin
               if (!out_valid || out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   act_packer #(.PACK_W(PACK_W)) u_packer (
      .clk        (clk),
      .rst        (rst),
      .bit_vld    (act_vld),
      .bit_dat    (act_bit),
      .flush_vld  (state == S_FLUSH),
      .out_ready  (out_ready),
      .out_word   (out_word),
      .out_valid  (out_valid),
      .bit_cnt_nz (bit_cnt_nz)
   );

endmodule

// File: tb/tb_popcount_threshold_packer.sv
// Directed bench for popcount_threshold_packer; narrow accumulator so saturation is reachable.
module tb_popcount_threshold_packer;

   localparam int ACC_W  = 6;
   localparam int NCH_W  = 8;
   localparam int PACK_W = 8;

`ifdef POPACC_SAT_EN
   localparam logic SAT = 1'b1;
`else
   localparam logic SAT = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [4:0]              mac_in = '0;
   logic                    mac_valid = 1'b0;
   logic                    mac_ready;
   logic [4:0]              kernel_size = '0;
   logic                    operation = 1'b0;
   logic [NCH_W-1:0]        num_ch = '0;
   logic signed [ACC_W+1:0] threshold = '0;
   logic                    flush = 1'b0;
   logic [PACK_W-1:0]       out_word;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic                    busy;
   logic                    sat_flag;

   int nchecks = 0;
   int nerr    = 0;

   popcount_threshold_packer #(.ACC_W(ACC_W), .NCH_W(NCH_W), .PACK_W(PACK_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .mac_in      (mac_in),
      .mac_valid   (mac_valid),
      .mac_ready   (mac_ready),
      .kernel_size (kernel_size),
      .operation   (operation),
      .num_ch      (num_ch),
      .threshold   (threshold),
      .flush       (flush),
      .out_word    (out_word),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .sat_flag    (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [4:0] m);
      int n = 0;
      mac_in    = m;
      mac_valid = 1'b1;
      #1;
      while (!mac_ready && n < 100) begin
         step();
         n++;
      end
      chk("beat_ready", 32'(mac_ready), 32'd1);
      step();
      mac_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      chk("out_valid_wait", 32'(out_valid), 32'd1);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      step();
      step();
      chk("rst_mac_ready", 32'(mac_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_word",  32'(out_word),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_sat_flag",  32'(sat_flag),  32'd0);
      rst = 1'b0;
      step();

      // 3x3, two channels: 9+9 -> dot 18 -> 1; threshold changed mid-pixel must not matter
      kernel_size = 5'b00100;
      operation   = 1'b0;
      num_ch      = 8'd2;
      threshold   = '0;
      beat(5'd9);
      chk("acc_busy", 32'(busy), 32'd1);
      threshold = 8'sd100;
      beat(5'd9);
      threshold = '0;
      beat(5'd2);
      beat(5'd3);
      kernel_size = 5'b00001;
      num_ch      = 8'd1;
      for (int i = 0; i < 5; i++) beat(5'd1);
      chk("pre_word_valid", 32'(out_valid), 32'd0);
      beat(5'd1);
      chk("conv_word_valid", 32'(out_valid), 32'd1);
      chk("conv_word",       32'(out_word),  32'h0000_00FD);

      // 1x1 alternating 1,0 -> 0x55, valid right after the 8th beat
      for (int i = 0; i < 8; i++) beat((i % 2 == 0) ? 5'd1 : 5'd0);
      chk("alt_word_valid", 32'(out_valid), 32'd1);
      chk("alt_word",       32'(out_word),  32'h0000_0055);

      // Backpressure: word holds, input stalls
      out_ready = 1'b0;
      mac_in    = 5'd0;
      mac_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_mac_ready", 32'(mac_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_word",  32'(out_word),  32'h0000_0055);
         step();
      end
      mac_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(mac_ready), 32'd1);
      step();
      chk("bp_after_valid", 32'(out_valid), 32'd0);
      chk("bp_after_busy",  32'(busy),      32'd0);

      // Pooling bypass ignores num_ch; flush emits the partial word
      operation = 1'b1;
      num_ch    = 8'd5;
      beat(5'd1);
      beat(5'd3);
      beat(5'd6);
      chk("pool_busy", 32'(busy), 32'd1);
      pulse_flush();
      chk("flush_mac_ready", 32'(mac_ready), 32'd0);
      wait_out();
      chk("pool_word", 32'(out_word), 32'h0000_0003);
      chk("pool_busy_pending", 32'(busy), 32'd1);
      step();
      chk("pool_busy_done", 32'(busy), 32'd0);

      // Flush with nothing packed is ignored
      pulse_flush();
      step();
      chk("empty_flush_valid", 32'(out_valid), 32'd0);
      chk("empty_flush_busy",  32'(busy),      32'd0);

      // 5x5, four channels of 25: 6-bit accumulator overflows on the third beat
      operation   = 1'b0;
      kernel_size = 5'b10000;
      num_ch      = 8'd4;
      threshold   = '0;
      beat(5'd25);
      beat(5'd25);
      chk("sat_before", 32'(sat_flag), 32'd0);
      beat(5'd25);
      chk("sat_flag", 32'(sat_flag), 32'(SAT));
      beat(5'd25);
      pulse_flush();
      wait_out();
      chk("sat_word", 32'(out_word), 32'(SAT));
      step();

      // Reset mid-pixel discards the first beat
      kernel_size = 5'b00100;
      num_ch      = 8'd3;
      beat(5'd9);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_mac_ready", 32'(mac_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_word",  32'(out_word),  32'd0);
      chk("mid_rst_busy",      32'(busy),      32'd0);
      chk("mid_rst_sat_flag",  32'(sat_flag),  32'd0);
      rst = 1'b0;
      step();
      beat(5'd4);
      beat(5'd4);
      beat(5'd4);
      chk("post_rst_busy", 32'(busy), 32'd1);
      pulse_flush();
      wait_out();
      chk("post_rst_word", 32'(out_word), 32'd0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
